axis_reframe: RTL and testbench
===============================

Name: axis_reframe

Overview:
- Downstream neighbour of the tlast-stripping stage.
- Input is a payload stream with no valid tlast beats. End of frame is signalled only by a sideband marker: s_axis_tlast=1 while s_axis_tvalid=0.
- The block rebuilds proper AXI-Stream framing by holding back the most recent beat until the frame end is known. Frame end is the marker, a beat-count limit, or an idle timeout. The final beat then goes out with m_axis_tlast=1.

Parameters:
- DATA_WIDTH, 64, tdata width in bits.
- MAX_BEATS, 256, maximum beats per output frame; the frame is forced closed when reached. Must be ≥1.
- TIMEOUT_CYCLES, 1024, number of idle cycles in HOLD before a forced close; 0 disables the timer.
- CNT_W, $clog2(MAX_BEATS+1), derived width of the beat counter; not overridden.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- s_axis_tready  out  1  upstream ready.
- s_axis_tdata  in  DATA_WIDTH  payload.
- s_axis_tlast  in  1  end-of-frame marker; meaningful only when s_axis_tvalid=0.
- s_axis_tvalid  in  1  payload valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  DATA_WIDTH  payload.
- m_axis_tlast  out  1  last beat of the rebuilt frame.
- m_axis_tvalid  out  1  output valid.
- frame_done  out  1  one-cycle pulse on the handshake of an m_axis_tlast=1 beat.

Behaviour:
- Reset (rst=0, async) clears everything:
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, frame_done=0.
  - state=IDLE, cnt=0, timer=0, hold register invalid.
- Storage is a hold register (1 beat) plus an output register (1 beat).
  - out_free = !m_axis_tvalid || m_axis_tready.
  - Handshakes: beat_acc = s_axis_tvalid && s_axis_tready; mark_acc = s_axis_tlast && !s_axis_tvalid && s_axis_tready.
- s_axis_tready = (state==IDLE) || (state==HOLD && cnt<MAX_BEATS && out_free).
- IDLE (hold empty):
  - beat_acc → load hold, cnt=1, timer=0, go to HOLD.
  - mark_acc → discarded (empty frame); no output, stay in IDLE.
- HOLD (hold full, cnt beats in the current frame including the held one):
  - beat_acc:
    - Hold moves to out with tlast=0; the new beat loads into hold.
    - cnt+1, timer=0.
  - Otherwise, if mark_acc, or (TIMEOUT_CYCLES≠0 && timer==TIMEOUT_CYCLES-1), or cnt==MAX_BEATS, the frame closes:
    - A close waits while out_free=0, with ready kept low; the close cause stays pending.
    - When out_free=1, hold moves to out with tlast=1; cnt=0, timer=0, go to IDLE.
  - Otherwise timer+1; it saturates while out is blocked.
- A beat and a marker can never coincide (the marker requires tvalid=0).
- A beat arriving on the timeout cycle wins: no close, timer restarts.
- When cnt reaches MAX_BEATS, s_axis_tready drops until the close transfer completes.
- m_axis output:
  - Standard AXIS: tdata/tlast held stable while tvalid=1 && tready=0.
  - tvalid clears on handshake unless reloaded the same cycle.
  - Full throughput of 1 beat/cycle in steady state.
- Latency:
  - A beat appears on m_axis one cycle after its release event.
  - The release event is the next beat accepted or a frame close.
  - Minimum input-to-output latency is 2 cycles.
- frame_done is registered: it pulses the cycle after m_axis_tvalid && m_axis_tready && m_axis_tlast.
- Beat order is strictly preserved. No beat is ever dropped or duplicated.
- Reset mid-frame: held and output beats are lost; the next frame starts clean.

Decomposition:
- Shared package axis_pkg:
  - State enum {IDLE, HOLD}.
  - Helper function for CNT_W.
  - Default DATA_WIDTH constant shared with the strip stage.
- No sub-module.
  - The output register is inline logic, not a generic skid buffer, because it is loaded only from hold with a computed tlast.

Test Plan:
- 3 beats A,B,C (tready=1), then one marker cycle → m_axis emits A,B,C with tlast on C only; frame_done pulses once; s_axis_tready never drops.
- MAX_BEATS=4, continuous 10 beats, no marker → frames of 4,4 plus 2 held; the 2 held beats close only via marker or timeout. tlast on beats 4 and 8; ready low for exactly 1 cycle at each close.
- TIMEOUT_CYCLES=8, one beat then idle → beat emitted with tlast=1 at cycle 8 after acceptance (+1 register); a beat arriving on cycle 7 resets the timer and no close occurs.
- Marker while IDLE → no m_axis_tvalid, no frame_done, state stays IDLE.
- m_axis_tready toggled randomly 50% over a 100-beat stream with markers every 7 beats → scoreboard: data order intact; tlast on every 7th beat and the final beat; tdata stable while stalled.
- rst asserted while in HOLD with m_axis_tvalid=1 → outputs zero immediately (async); after release a fresh 2-beat frame plus marker emits correctly.

Source files
------------

// File: rtl/axis_pkg.sv
// Shared types and constants for the AXI-Stream framing stages.
package axis_pkg;

  localparam int unsigned AXIS_DATA_WIDTH = 64;

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  // Width needed to hold 0..n; at least 1 bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/axis_reframe_if.sv
// AXI-Stream bundle (tdata/tlast/tvalid/tready) with master/slave views.
interface axis_reframe_if
  import axis_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = AXIS_DATA_WIDTH
) ();

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tlast, input tvalid, output tready);

endinterface

// File: rtl/axis_reframe.sv
// Rebuilds AXI-Stream tlast framing by holding back the newest beat until the
// frame end is known (sideband marker, beat-count limit or idle timeout).
module axis_reframe
  import axis_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = AXIS_DATA_WIDTH,
  parameter int unsigned MAX_BEATS      = 256,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = cnt_width(MAX_BEATS)
) (
  input  logic           clk,
  input  logic           rst,
  axis_reframe_if.slave  s_axis,
  axis_reframe_if.master m_axis,
  output logic           frame_done
);

  localparam int unsigned TMR_W    = cnt_width(TIMEOUT_CYCLES);
  localparam int unsigned TMO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [TMR_W-1:0]      timer, timer_nxt;
  logic [DATA_WIDTH-1:0] hold_data;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_last;

  logic out_free;
  logic s_ready;
  logic beat_acc;
  logic mark_acc;
  logic at_max;
  logic timeout_hit;
  logic load_hold;
  logic load_out;
  logic load_last;

  assign out_free    = !out_valid || m_axis.tready;
  assign at_max      = (cnt == CNT_W'(MAX_BEATS));
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (timer == TMR_W'(TMO_LAST));
  assign s_ready     = (state == IDLE) ||
                       ((state == HOLD) && (cnt < CNT_W'(MAX_BEATS)) && out_free);
  assign beat_acc    = s_axis.tvalid && s_ready;
  assign mark_acc    = s_axis.tlast && !s_axis.tvalid && s_ready;

  assign s_axis.tready = s_ready;
  assign m_axis.tdata  = out_data;
  assign m_axis.tlast  = out_last;
  assign m_axis.tvalid = out_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      timer <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      timer <= timer_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    timer_nxt = timer;
    load_hold = 1'b0;
    load_out  = 1'b0;
    load_last = 1'b0;
    unique case (state)
      IDLE: begin
        // A marker with nothing held is an empty frame and is dropped.
        if (beat_acc) begin
          load_hold = 1'b1;
          cnt_nxt   = CNT_W'(1);
          timer_nxt = '0;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (beat_acc) begin
          load_hold = 1'b1;
          load_out  = 1'b1;
          cnt_nxt   = cnt + CNT_W'(1);
          timer_nxt = '0;
        end else if (mark_acc || timeout_hit || at_max) begin
          // Timeout and count causes persist on their own while out is blocked.
          if (out_free) begin
            load_out  = 1'b1;
            load_last = 1'b1;
            cnt_nxt   = '0;
            timer_nxt = '0;
            state_nxt = IDLE;
          end
        end else if ((TIMEOUT_CYCLES != 0) && !timeout_hit) begin
          timer_nxt = timer + TMR_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_data  <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (load_hold) begin
        hold_data <= s_axis.tdata;
      end
      if (load_out) begin
        out_data  <= hold_data;
        out_last  <= load_last;
        out_valid <= 1'b1;
      end else if (m_axis.tready) begin
        out_valid <= 1'b0;
      end
      frame_done <= out_valid && m_axis.tready && out_last;
    end
  end

endmodule

// File: tb/tb_axis_reframe.sv
// Directed bench for axis_reframe: two instances (small limits / no timeout).
module tb_axis_reframe;

  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axis_reframe_if #(.DATA_WIDTH(DW)) sa ();
  axis_reframe_if #(.DATA_WIDTH(DW)) ma ();
  axis_reframe_if #(.DATA_WIDTH(DW)) sb ();
  axis_reframe_if #(.DATA_WIDTH(DW)) mb ();

  logic          sel = 1'b0;
  logic          drv_valid = 1'b0;
  logic          drv_last = 1'b0;
  logic [DW-1:0] drv_data = '0;
  logic          drv_mready = 1'b0;
  logic          fd_a, fd_b;

  assign sa.tvalid = drv_valid & ~sel;
  assign sa.tlast  = drv_last & ~sel;
  assign sa.tdata  = drv_data;
  assign ma.tready = drv_mready & ~sel;
  assign sb.tvalid = drv_valid & sel;
  assign sb.tlast  = drv_last & sel;
  assign sb.tdata  = drv_data;
  assign mb.tready = drv_mready & sel;

  axis_reframe #(.DATA_WIDTH(DW), .MAX_BEATS(4), .TIMEOUT_CYCLES(8)) dut_a (
    .clk(clk), .rst(rst_n), .s_axis(sa), .m_axis(ma), .frame_done(fd_a)
  );

  axis_reframe #(.DATA_WIDTH(DW), .MAX_BEATS(16), .TIMEOUT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst_n), .s_axis(sb), .m_axis(mb), .frame_done(fd_b)
  );

  logic          o_sready, o_mvalid, o_mlast, o_fd;
  logic [DW-1:0] o_mdata;
  assign o_sready = sel ? sb.tready : sa.tready;
  assign o_mvalid = sel ? mb.tvalid : ma.tvalid;
  assign o_mlast  = sel ? mb.tlast  : ma.tlast;
  assign o_mdata  = sel ? mb.tdata  : ma.tdata;
  assign o_fd     = sel ? fd_b : fd_a;

  int n_assert = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic l, input logic [DW-1:0] d);
    drv_valid = v;
    drv_last  = l;
    drv_data  = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int            sent, nout, low_cnt, cyc, idx, rcvd, nfd, n_items;
  logic          acc, prev_stall, prev_last;
  logic [DW-1:0] prev_data;
  logic [DW-1:0] item_data[$];
  bit            item_mark[$];

  initial begin
    // Reset values while reset is held
    drv_mready = 1'b1;
    #12;
    check("rst_mvalid", o_mvalid, 0);
    check("rst_mlast", o_mlast, 0);
    check("rst_mdata", o_mdata, 0);
    check("rst_fd", o_fd, 0);
    #5 rst_n = 1'b1;
    step();

    // Three beats then a marker
    drive(1, 0, 16'hA0A0); step();
    check("t1_v0", o_mvalid, 0);
    check("t1_rdy0", o_sready, 1);
    drive(1, 0, 16'hB1B1); step();
    check("t1_a_v", o_mvalid, 1);
    check("t1_a_d", o_mdata, 16'hA0A0);
    check("t1_a_l", o_mlast, 0);
    check("t1_rdy1", o_sready, 1);
    drive(1, 0, 16'hC2C2); step();
    check("t1_b_d", o_mdata, 16'hB1B1);
    check("t1_b_l", o_mlast, 0);
    check("t1_rdy2", o_sready, 1);
    drive(0, 1, '0); step();
    check("t1_c_v", o_mvalid, 1);
    check("t1_c_d", o_mdata, 16'hC2C2);
    check("t1_c_l", o_mlast, 1);
    check("t1_fd_early", o_fd, 0);
    drive(0, 0, '0); step();
    check("t1_v_clr", o_mvalid, 0);
    check("t1_fd", o_fd, 1);
    step();
    check("t1_fd_once", o_fd, 0);

    // Marker with nothing held
    drive(0, 1, '0); step();
    check("t4_v", o_mvalid, 0);
    check("t4_rdy", o_sready, 1);
    drive(0, 0, '0); step();
    check("t4_v2", o_mvalid, 0);
    check("t4_fd", o_fd, 0);

    // Beat-count limit of 4 with ten continuous beats
    sent = 0; nout = 0; low_cnt = 0; cyc = 0;
    while (sent < 10 && cyc < 40) begin
      cyc++;
      drive(1, 0, DW'(16'h0100 + sent));
      acc = o_sready;
      step();
      if (acc) sent++;
      if (o_mvalid) begin
        check("t2_d", o_mdata, 16'h0100 + nout);
        check("t2_l", o_mlast, (nout == 3 || nout == 7) ? 1 : 0);
        nout++;
      end
      if (sent < 10 && !o_sready) low_cnt++;
    end
    check("t2_sent", sent, 10);
    check("t2_nout", nout, 9);
    check("t2_ready_low", low_cnt, 2);
    drive(0, 1, '0); step();
    check("t2_last_v", o_mvalid, 1);
    check("t2_last_d", o_mdata, 16'h0109);
    check("t2_last_l", o_mlast, 1);
    drive(0, 0, '0); step();
    check("t2_fd", o_fd, 1);

    // Idle timeout of 8 cycles
    drive(1, 0, 16'h5A5A); step();
    drive(0, 0, '0);
    for (int i = 0; i < 7; i++) begin
      step();
      check("t3_wait", o_mvalid, 0);
    end
    step();
    check("t3_v", o_mvalid, 1);
    check("t3_d", o_mdata, 16'h5A5A);
    check("t3_l", o_mlast, 1);
    step();
    check("t3_fd", o_fd, 1);

    // Beat on the timeout cycle prevents the close
    drive(1, 0, 16'h1111); step();
    drive(0, 0, '0);
    for (int i = 0; i < 7; i++) step();
    check("t3b_wait", o_mvalid, 0);
    drive(1, 0, 16'h2222); step();
    check("t3b_v", o_mvalid, 1);
    check("t3b_d", o_mdata, 16'h1111);
    check("t3b_l", o_mlast, 0);
    drive(0, 1, '0); step();
    check("t3b_z_d", o_mdata, 16'h2222);
    check("t3b_z_l", o_mlast, 1);
    drive(0, 0, '0); step();

    // Asynchronous reset while holding with output stalled
    drv_mready = 1'b0;
    drive(1, 0, 16'h0AAA); step();
    drive(1, 0, 16'h0BBB); step();
    check("t6_pre_v", o_mvalid, 1);
    check("t6_pre_d", o_mdata, 16'h0AAA);
    drive(0, 0, '0);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_v", o_mvalid, 0);
    check("t6_rst_d", o_mdata, 0);
    check("t6_rst_l", o_mlast, 0);
    #2 rst_n = 1'b1;
    step();
    drv_mready = 1'b1;
    drive(1, 0, 16'h0CCC); step();
    check("t6_v0", o_mvalid, 0);
    drive(1, 0, 16'h0DDD); step();
    check("t6_r_d", o_mdata, 16'h0CCC);
    check("t6_r_l", o_mlast, 0);
    drive(0, 1, '0); step();
    check("t6_s_d", o_mdata, 16'h0DDD);
    check("t6_s_l", o_mlast, 1);
    drive(0, 0, '0); step();
    check("t6_fd", o_fd, 1);

    // Random backpressure over 100 beats with a marker every 7 beats
    sel = 1'b1;
    for (int i = 0; i < 100; i++) begin
      item_data.push_back(DW'(16'h4000 + i));
      item_mark.push_back(1'b0);
      if ((i + 1) % 7 == 0 || i == 99) begin
        item_data.push_back('0);
        item_mark.push_back(1'b1);
      end
    end
    n_items = item_data.size();
    idx = 0; rcvd = 0; nfd = 0; cyc = 0; prev_stall = 1'b0;
    prev_data = '0; prev_last = 1'b0;
    step();
    while ((idx < n_items || rcvd < 100) && cyc < 3000) begin
      cyc++;
      drv_mready = 1'($urandom_range(0, 1));
      if (idx < n_items && $urandom_range(0, 3) != 0)
        drive(!item_mark[idx], item_mark[idx], item_data[idx]);
      else
        drive(0, 0, '0);
      #1;
      if (prev_stall) begin
        check("t5_stall_v", o_mvalid, 1);
        check("t5_stall_d", o_mdata, prev_data);
        check("t5_stall_l", o_mlast, prev_last);
      end
      if (o_fd) nfd++;
      if (o_mvalid && drv_mready && rcvd < 100) begin
        check("t5_d", o_mdata, 16'h4000 + rcvd);
        check("t5_l", o_mlast, ((rcvd + 1) % 7 == 0 || rcvd == 99) ? 1 : 0);
        rcvd++;
      end
      prev_stall = o_mvalid && !drv_mready;
      prev_data  = o_mdata;
      prev_last  = o_mlast;
      if (o_sready && (drv_valid || drv_last)) idx++;
      @(posedge clk);
      #1;
    end
    drive(0, 0, '0);
    drv_mready = 1'b1;
    if (o_fd) nfd++;
    check("t5_rcvd", rcvd, 100);
    step();
    check("t5_drained", o_mvalid, 0);
    check("t5_nfd", nfd, 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
